// File: rtl/dag_addr_gen_if.sv
// Sequencer <-> data address generator bus: generation requests, register access,
// and the two registered outputs (memory address and register read data).
interface dag_addr_gen_if #(
  parameter int DMA_SIZE = 3,
  parameter int DMD_SIZE = 4
);
  logic                ps_dg_en;
  logic                ps_dg_pre;
  logic [1:0]          ps_dg_iadd;
  logic [1:0]          ps_dg_madd;
  logic                ps_dg_wrt;
  logic                ps_dg_rd;
  logic [3:0]          ps_dg_rgadd;
  logic [DMD_SIZE-1:0] bc_dt;
  logic [DMA_SIZE-1:0] dg_dm_add;
  logic [DMD_SIZE-1:0] dg_bc_dt;

  modport master (
    output ps_dg_en, ps_dg_pre, ps_dg_iadd, ps_dg_madd,
    output ps_dg_wrt, ps_dg_rd, ps_dg_rgadd, bc_dt,
    input  dg_dm_add, dg_bc_dt
  );

  modport slave (
    input  ps_dg_en, ps_dg_pre, ps_dg_iadd, ps_dg_madd,
    input  ps_dg_wrt, ps_dg_rd, ps_dg_rgadd, bc_dt,
    output dg_dm_add, dg_bc_dt
  );
endinterface

// File: rtl/dag_addr_gen.sv
// Data address generator: four I/M/L/B sets, pre/post modify with linear or
// circular-buffer wrap, index write-back, and register load/readback over bc_dt.
module dag_addr_gen #(
  parameter int DMA_SIZE = 3,
  parameter int DMD_SIZE = 4
) (
  input  logic          clk,
  input  logic          rstb,
  dag_addr_gen_if.slave bus
);

  localparam int SW = DMA_SIZE + 2;

  typedef logic [DMA_SIZE-1:0] addr_t;

  addr_t i_reg [4];
  addr_t m_reg [4];
  addr_t l_reg [4];
  addr_t b_reg [4];
  addr_t i_next [4];
  addr_t m_next [4];
  addr_t l_next [4];
  addr_t b_next [4];

  addr_t               cur_i, cur_m, cur_l, cur_b;
  addr_t               upd_addr, rd_val, wr_data;
  logic [1:0]          wrap_hi_unused;
  logic signed [SW-1:0] sum, bound, wrapped;

  addr_t               dm_add_reg, dm_add_next;
  logic [DMD_SIZE-1:0] bc_dt_reg, bc_dt_next;

  generate
    if (DMD_SIZE > DMA_SIZE) begin : g_wide_bus
      logic bc_dt_hi_unused;
      assign bc_dt_hi_unused = |bus.bc_dt[DMD_SIZE-1:DMA_SIZE];
    end
  endgenerate

  assign wr_data = bus.bc_dt[DMA_SIZE-1:0];
  assign cur_i   = i_reg[bus.ps_dg_iadd];
  assign cur_m   = m_reg[bus.ps_dg_madd];
  assign cur_l   = l_reg[bus.ps_dg_iadd];
  assign cur_b   = b_reg[bus.ps_dg_iadd];

  // Two guard bits keep I+M and B+L exact so the wrap compares are signed and overflow-free.
  always_comb begin
    sum     = $signed({2'b00, cur_i}) + $signed({{2{cur_m[DMA_SIZE-1]}}, cur_m});
    bound   = $signed({2'b00, cur_b}) + $signed({2'b00, cur_l});
    wrapped = sum;
    if (cur_l != '0) begin
      if (!cur_m[DMA_SIZE-1] && (sum >= bound)) begin
        wrapped = sum - $signed({2'b00, cur_l});
      end else if (cur_m[DMA_SIZE-1] && (sum < $signed({2'b00, cur_b}))) begin
        wrapped = sum + $signed({2'b00, cur_l});
      end
    end
  end

  // Truncation gives the linear (L=0) modulo wrap for free.
  assign {wrap_hi_unused, upd_addr} = wrapped;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_set
      logic wr_i, wr_m, wr_l, wr_b, gen_hit;
      assign wr_i    = bus.ps_dg_wrt && (bus.ps_dg_rgadd == {2'b00, 2'(gi)});
      assign wr_m    = bus.ps_dg_wrt && (bus.ps_dg_rgadd == {2'b01, 2'(gi)});
      assign wr_l    = bus.ps_dg_wrt && (bus.ps_dg_rgadd == {2'b10, 2'(gi)});
      assign wr_b    = bus.ps_dg_wrt && (bus.ps_dg_rgadd == {2'b11, 2'(gi)});
      assign gen_hit = bus.ps_dg_en && (bus.ps_dg_iadd == 2'(gi));
      // An explicit register write takes priority over the index write-back.
      assign i_next[gi] = wr_i ? wr_data : (gen_hit ? upd_addr : i_reg[gi]);
      assign m_next[gi] = wr_m ? wr_data : m_reg[gi];
      assign l_next[gi] = wr_l ? wr_data : l_reg[gi];
      assign b_next[gi] = wr_b ? wr_data : b_reg[gi];
    end
  endgenerate

  always_comb begin
    rd_val = '0;
    case (bus.ps_dg_rgadd[3:2])
      2'b00:   rd_val = i_reg[bus.ps_dg_rgadd[1:0]];
      2'b01:   rd_val = m_reg[bus.ps_dg_rgadd[1:0]];
      2'b10:   rd_val = l_reg[bus.ps_dg_rgadd[1:0]];
      default: rd_val = b_reg[bus.ps_dg_rgadd[1:0]];
    endcase
  end

  always_comb begin
    dm_add_next = dm_add_reg;
    bc_dt_next  = bc_dt_reg;
    if (bus.ps_dg_en) begin
      dm_add_next = bus.ps_dg_pre ? upd_addr : cur_i;
    end
    if (bus.ps_dg_rd) begin
      bc_dt_next = DMD_SIZE'(rd_val);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int k = 0; k < 4; k++) begin
        i_reg[k] <= '0;
        m_reg[k] <= '0;
        l_reg[k] <= '0;
        b_reg[k] <= '0;
      end
      dm_add_reg <= '0;
      bc_dt_reg  <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        i_reg[k] <= i_next[k];
        m_reg[k] <= m_next[k];
        l_reg[k] <= l_next[k];
        b_reg[k] <= b_next[k];
      end
      dm_add_reg <= dm_add_next;
      bc_dt_reg  <= bc_dt_next;
    end
  end

  assign bus.dg_dm_add = dm_add_reg;
  assign bus.dg_bc_dt  = bc_dt_reg;

endmodule

// File: tb/tb_dag_addr_gen.sv
// Randomized and directed check of dag_addr_gen against an arithmetic reference model.
module tb_dag_addr_gen;

  localparam int A   = 3;
  localparam int D   = 4;
  localparam int MOD = 1 << A;

  logic clk;
  logic rstb;

  dag_addr_gen_if #(.DMA_SIZE(A), .DMD_SIZE(D)) bus ();

  dag_addr_gen #(.DMA_SIZE(A), .DMD_SIZE(D)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: register file indexed by type (0=I,1=M,2=L,3=B) and number.
  int regs [4][4];
  int exp_addr;
  int exp_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap8(input int v);
    return ((v % MOD) + MOD) % MOD;
  endfunction

  function automatic int next_index(input int i, input int m_raw, input int l, input int b);
    int m;
    int s;
    m = (m_raw >= MOD / 2) ? m_raw - MOD : m_raw;
    s = i + m;
    if (l != 0) begin
      if (m >= 0 && s >= b + l) s = s - l;
      else if (m < 0 && s < b) s = s + l;
    end
    return wrap8(s);
  endfunction

  task automatic model_reset();
    for (int t = 0; t < 4; t++)
      for (int n = 0; n < 4; n++)
        regs[t][n] = 0;
    exp_addr = 0;
    exp_rd   = 0;
  endtask

  // One clock: drive inputs, predict, clock, check both outputs, commit model state.
  task automatic cycle(input bit en, input bit pre, input int iadd, input int madd,
                       input bit wrt, input bit rd, input int rgadd, input int data,
                       input string tag);
    int u;
    @(negedge clk);
    bus.ps_dg_en    = en;
    bus.ps_dg_pre   = pre;
    bus.ps_dg_iadd  = 2'(iadd);
    bus.ps_dg_madd  = 2'(madd);
    bus.ps_dg_wrt   = wrt;
    bus.ps_dg_rd    = rd;
    bus.ps_dg_rgadd = 4'(rgadd);
    bus.bc_dt       = 4'(data);
    u = next_index(regs[0][iadd], regs[1][madd], regs[2][iadd], regs[3][iadd]);
    if (en) exp_addr = pre ? u : regs[0][iadd];
    if (rd) exp_rd = regs[rgadd / 4][rgadd % 4];
    @(posedge clk);
    #1;
    check({tag, "_addr"}, 32'(bus.dg_dm_add), 32'(exp_addr));
    check({tag, "_rd"},   32'(bus.dg_bc_dt),  32'(exp_rd));
    $display("%s en=%0d pre=%0d iadd=%0d madd=%0d wrt=%0d rd=%0d rg=%0d dat=%0d -> addr=%0d rd=%0d",
             tag, en, pre, iadd, madd, wrt, rd, rgadd, data, bus.dg_dm_add, bus.dg_bc_dt);
    if (en) regs[0][iadd] = u;
    if (wrt) regs[rgadd / 4][rgadd % 4] = data % MOD;
  endtask

  task automatic wr(input int rgadd, input int data);
    cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, rgadd, data, "wr");
  endtask

  initial begin
    bus.ps_dg_en = 0; bus.ps_dg_pre = 0; bus.ps_dg_iadd = 0; bus.ps_dg_madd = 0;
    bus.ps_dg_wrt = 0; bus.ps_dg_rd = 0; bus.ps_dg_rgadd = 0; bus.bc_dt = 0;
    rstb = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_addr", 32'(bus.dg_dm_add), 32'd0);
    check("reset_rd",   32'(bus.dg_bc_dt),  32'd0);
    @(negedge clk);
    rstb = 1'b1;

    // Circular post-modify
    wr(4'b1100, 2); wr(4'b1000, 4); wr(4'b0000, 5); wr(4'b0100, 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, "tp1a");
    check("tp1a_const", 32'(bus.dg_dm_add), 32'd5);
    cycle(1, 0, 0, 0, 0, 1, 4'b0000, 0, "tp1b");
    check("tp1b_const", 32'(bus.dg_dm_add), 32'd2);
    check("tp1b_old_i", 32'(bus.dg_bc_dt),  32'd2);
    cycle(0, 0, 0, 0, 0, 1, 4'b0000, 0, "tp1c");
    check("tp1c_i0", 32'(bus.dg_bc_dt), 32'd3);

    // Negative modify wrap
    wr(4'b0000, 2); wr(4'b0101, 7);
    cycle(1, 0, 0, 1, 0, 0, 0, 0, "tp2a");
    check("tp2a_const", 32'(bus.dg_dm_add), 32'd2);
    cycle(0, 0, 0, 0, 0, 1, 4'b0000, 0, "tp2b");
    check("tp2b_i0", 32'(bus.dg_bc_dt), 32'd5);

    // Pre-modify, then linear wrap
    wr(4'b0001, 3); wr(4'b1001, 0);
    cycle(1, 1, 1, 0, 0, 0, 0, 0, "tp3a");
    check("tp3a_const", 32'(bus.dg_dm_add), 32'd4);
    cycle(0, 0, 0, 0, 0, 1, 4'b0001, 0, "tp3b");
    check("tp3b_i1", 32'(bus.dg_bc_dt), 32'd4);
    wr(4'b0001, 7);
    cycle(1, 1, 1, 0, 0, 0, 0, 0, "tp3c");
    check("tp3c_const", 32'(bus.dg_dm_add), 32'd0);
    cycle(0, 0, 0, 0, 0, 1, 4'b0001, 0, "tp3d");
    check("tp3d_i1", 32'(bus.dg_bc_dt), 32'd0);

    // Register readback, read-during-write returns old value
    wr(4'b1110, 4'hD);
    cycle(0, 0, 0, 0, 0, 1, 4'b1110, 0, "tp4a");
    check("tp4a_const", 32'(bus.dg_bc_dt), 32'd5);
    cycle(0, 0, 0, 0, 1, 1, 4'b1110, 3, "tp4b");
    check("tp4b_old", 32'(bus.dg_bc_dt), 32'd5);
    cycle(0, 0, 0, 0, 0, 1, 4'b1110, 0, "tp4c");
    check("tp4c_new", 32'(bus.dg_bc_dt), 32'd3);

    // Collision: register write to I0 beats the write-back
    wr(4'b0000, 3); wr(4'b0100, 2);
    cycle(1, 0, 0, 0, 1, 0, 4'b0000, 6, "tp5a");
    check("tp5a_const", 32'(bus.dg_dm_add), 32'd3);
    cycle(0, 0, 0, 0, 0, 1, 4'b0000, 0, "tp5b");
    check("tp5b_i0", 32'(bus.dg_bc_dt), 32'd6);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 1) == 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3), ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
            $urandom_range(0, 15), $urandom_range(0, 15), "rnd");
    end

    // Reset mid-stream, between edges
    repeat (3) cycle(1, 0, 0, 0, 0, 1, 0, 0, "pre_rst");
    @(negedge clk);
    #2;
    rstb = 1'b0;
    #1;
    check("rst_async_addr", 32'(bus.dg_dm_add), 32'd0);
    check("rst_async_rd",   32'(bus.dg_bc_dt),  32'd0);
    model_reset();
    @(negedge clk);
    rstb = 1'b1;
    for (int r = 0; r < 16; r++) begin
      cycle(0, 0, 0, 0, 0, 1, r, 0, "post_rst");
      check("post_rst_zero", 32'(bus.dg_bc_dt), 32'd0);
    end

    // A little more random traffic after reset
    for (int n = 0; n < 100; n++) begin
      cycle(($urandom_range(0, 1) == 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3), ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
            $urandom_range(0, 15), $urandom_range(0, 15), "rnd2");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dag_addr_gen.md
Name: dag_addr_gen

Overview:
- Data address generator that drives the data-memory address bus `dg_dm_add` consumed by the internal data memory.
- Holds four address sets (I index, M modify, L length, B base), each DMA_SIZE bits.
- On a sequencer request it produces a pre- or post-modified address, with linear or circular-buffer wrap, and writes the updated index back.
- Registers are loaded and read over the bc_dt data bus.

Parameters:
- DMA_SIZE, 3, address width; width of every I/M/L/B register and of dg_dm_add.
- DMD_SIZE, 4, data bus width; must be >= DMA_SIZE.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstb  input  1  asynchronous active-low reset.
- ps_dg_en  input  1  address-generation request.
- ps_dg_pre  input  1  1 = pre-modify, 0 = post-modify.
- ps_dg_iadd  input  2  index set select (I/L/B n).
- ps_dg_madd  input  2  modify register select (M n).
- ps_dg_wrt  input  1  register write strobe.
- ps_dg_rd  input  1  register read strobe.
- ps_dg_rgadd  input  4  register select: [3:2] type (00=I, 01=M, 10=L, 11=B), [1:0] number.
- bc_dt  input  DMD_SIZE  register write data; low DMA_SIZE bits used.
- dg_dm_add  output  DMA_SIZE  data-memory address, registered.
- dg_bc_dt  output  DMD_SIZE  register read data, registered, zero-extended.

Behaviour:
- Reset (rstb=0, asynchronous):
  - all 16 registers clear to 0.
  - dg_dm_add = 0 and dg_bc_dt = 0.
  - reset mid-generation discards any pending index update.
- Address generation, when ps_dg_en=1 at a clock edge. Let I=I[iadd], M=M[madd], L=L[iadd], B=B[iadd].
  - M is two's-complement signed.
  - Arithmetic is done in DMA_SIZE+2 bits: sum = I + sext(M).
  - Wrap rule, applied to sum to give U:
    - L = 0: U = sum mod 2^DMA_SIZE (linear).
    - L != 0, M >= 0, sum >= B+L: U = sum - L.
    - L != 0, M < 0, sum < B: U = sum + L.
    - otherwise U = sum.
  - Post-modify: dg_dm_add <= I; I[iadd] <= U.
  - Pre-modify: dg_dm_add <= U; I[iadd] <= U.
  - Latency: dg_dm_add is valid from the edge after the request. The sequencer asserts ps_dm_cslt on that cycle.
  - dg_dm_add holds its value when ps_dg_en=0.
  - Back-to-back requests every cycle are supported. Each request uses the index value written by the previous one.
  - Behaviour when I lies outside [B, B+L) is defined only by the arithmetic above; no special handling.
- Register write, when ps_dg_wrt=1: reg[rgadd] <= bc_dt[DMA_SIZE-1:0].
- Register read, when ps_dg_rd=1: dg_bc_dt <= zero-extended reg[rgadd], one-cycle latency.
  - dg_bc_dt holds its value otherwise.
  - A read in the same cycle as a write or update returns the old value (no bypass).
- Simultaneous events:
  - Write to I[n] in the same cycle as a generation updating I[n]: the register write wins.
  - Write to M/L/B in the same cycle as a generation that uses them: generation uses the old values.
  - ps_dg_wrt and ps_dg_rd together are both honoured.

Test Plan (DMA_SIZE=3, DMD_SIZE=4):
1. Circular post-modify:
   - Setup: B0=2, L0=4, I0=5, M0=1.
   - Action: post request on set 0.
   - Expect: dg_dm_add=5, then I0=2 (6 >= 6, wrap).
   - Action: next request.
   - Expect: dg_dm_add=2, I0=3.
2. Negative modify wrap:
   - Setup: B0=2, L0=4, I0=2, M1=7 (-1).
   - Action: post request with madd=1.
   - Expect: dg_dm_add=2, I0=5.
3. Pre-modify:
   - Setup: I1=3, M0=1, L1=0.
   - Action: pre request on set 1.
   - Expect: dg_dm_add=4, I1=4.
   - Linear wrap: I1=7, M0=1, pre request gives dg_dm_add=0, I1=0.
4. Register readback:
   - Action: write rgadd=4'b1110 (L2) with bc_dt=4'hD.
   - Expect: read on the next cycle gives dg_bc_dt=4'h5 (low 3 bits, zero-extended).
   - Action: read in the same cycle as a write.
   - Expect: old value returned.
5. Collision:
   - Setup: I0=3, M0=2.
   - Action: request on set 0 while writing I0=6.
   - Expect: dg_dm_add=3, I0=6.
6. Reset mid-operation:
   - Action: assert rstb=0 asynchronously between edges during a request stream.
   - Expect: dg_dm_add=0 and dg_bc_dt=0 immediately; all registers read back 0 after release.
